// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: constants, types and helpers shared by the multi-channel clock divider.
// Latency: none (declarations only).
// Backpressure: none.
package clkdiv_pkg;

  // Default divisor/counter width; the modules carry their own DIV_W parameter.
  parameter int DIV_W = 28;

  // Smallest divisor that still produces a low and a high phase.
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W-1:0] div_t;

  // Channel-select width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel -- counter, active/pending divisor, registered clk_out and tick.
// Latency: outputs registered; clk_out/tick reflect the counter value loaded on the same edge.
// Backpressure: none; divisor writes are staged and applied only on a period boundary.
// Optional build macro CLKDIV_SYNC_EN adds the sync_req phase-alignment input.
module clkdiv_channel #(
  parameter int DIV_W       = 28,
  parameter int DEFAULT_DIV = 200000
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_req,
`endif
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);
  import clkdiv_pkg::*;

  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] active_nxt;
  logic [DIV_W-1:0] pending_div;
  logic             wrap;
  logic             boundary;
  logic             sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_req;
`else
  assign sync_hit = 1'b0;
`endif

  // Period boundary: wrap, disable or sync all restart at cnt=0 and may swap in the pending divisor.
  always_comb begin
    wrap       = en && (cnt == active_div - DIV_W'(1));
    boundary   = !en || wrap || sync_hit;
    active_nxt = (pending && boundary) ? pending_div : active_div;
    cnt_nxt    = boundary ? '0 : cnt + DIV_W'(1);
  end

  // Counter, divisor staging and registered square-wave/tick outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      active_div  <= RESET_DIV;
      pending_div <= RESET_DIV;
      pending     <= 1'b0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      active_div <= active_nxt;
      // Low for floor(div/2) counts, high for the rest of the period.
      clk_out    <= en && !sync_hit && (cnt_nxt >= (active_nxt >> 1));
      tick       <= wrap && !sync_hit;
      // A write on a boundary edge: the old pending value is applied above, the new one stays pending.
      if (wr) begin
        pending_div <= wr_div;
        pending     <= 1'b1;
      end else if (boundary) begin
        pending     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N-channel programmable clock divider with per-channel enable, divisor, clk_out and tick.
// Latency: all outputs registered; cfg_err one cycle after the rejected write, divisors land on wrap.
// Backpressure: none; writes always complete, invalid ones are dropped and flagged on cfg_err.
// Optional build macro CLKDIV_SYNC_EN adds sync_req to realign every enabled channel.
module clkdiv_multi #(
  parameter  int N_CH        = 4,
  parameter  int DIV_W       = 28,
  parameter  int DEFAULT_DIV = 200000,
  localparam int CH_W        = clkdiv_pkg::ch_w(N_CH)
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_req,
`endif
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [N_CH-1:0]  cfg_pending,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);
  import clkdiv_pkg::*;

  // One extra bit so N_CH itself is representable when N_CH is a power of two.
  localparam logic [CH_W:0]    N_CH_LIM = (CH_W+1)'(N_CH);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(MIN_DIV);

  logic            cfg_ok;
  logic [N_CH-1:0] ch_wr;

  // Write validation and one-hot decode of the target channel.
  always_comb begin
    cfg_ok = ({1'b0, cfg_ch} < N_CH_LIM) && (cfg_div >= DIV_MIN);
    ch_wr  = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_wr[i] = cfg_wr && cfg_ok && (cfg_ch == CH_W'(i));
    end
  end

  // Rejected write flagged for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
`ifdef CLKDIV_SYNC_EN
      .sync_req(sync_req),
`endif
      .en      (ch_en[g]),
      .wr      (ch_wr[g]),
      .wr_div  (cfg_div),
      .pending (cfg_pending[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed bench for clkdiv_multi with a cycle scoreboard and fixed-pattern checks.
// Latency: expectations pushed when inputs are driven, popped 1 time unit after the next rising edge.
// Backpressure: none.
module tb_clkdiv_multi;
  localparam int N_CH        = 5;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 4;
  localparam int CH_W        = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [N_CH-1:0]  ch_en;
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;
  logic [N_CH-1:0]  cfg_pending;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
`ifdef CLKDIV_SYNC_EN
  logic             sync_req;
`endif

  clkdiv_multi #(
    .N_CH        (N_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
`ifdef CLKDIV_SYNC_EN
    .sync_req    (sync_req),
`endif
    .ch_en       (ch_en),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .cfg_pending (cfg_pending),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N_CH-1:0] clk;
    logic [N_CH-1:0] tck;
    logic [N_CH-1:0] pend;
    logic            err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state per channel.
  int m_cnt  [N_CH];
  int m_act  [N_CH];
  int m_pdiv [N_CH];
  bit m_pend [N_CH];

  logic [15:0] hc;
  logic [15:0] ht;
  logic [3:0]  pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit sync_val();
`ifdef CLKDIV_SYNC_EN
    return sync_req;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c]  = 0;
      m_act[c]  = DEFAULT_DIV;
      m_pdiv[c] = DEFAULT_DIV;
      m_pend[c] = 1'b0;
    end
  endtask

  // Advance the reference by one edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    bit s, en, wrap, bnd, acc;
    s     = sync_val();
    e.err = cfg_wr && !((int'(cfg_ch) < N_CH) && (int'(cfg_div) >= 2));
    for (int c = 0; c < N_CH; c++) begin
      en   = ch_en[c];
      acc  = cfg_wr && (int'(cfg_ch) == c) && (int'(cfg_div) >= 2);
      wrap = en && (m_cnt[c] == m_act[c] - 1);
      bnd  = !en || wrap || s;
      if (m_pend[c] && bnd) begin
        m_act[c]  = m_pdiv[c];
        m_pend[c] = 1'b0;
      end
      m_cnt[c]  = bnd ? 0 : m_cnt[c] + 1;
      e.clk[c]  = en && !s && (m_cnt[c] >= m_act[c] / 2);
      e.tck[c]  = wrap && !s;
      if (acc) begin
        m_pdiv[c] = int'(cfg_div);
        m_pend[c] = 1'b1;
      end
      e.pend[c] = m_pend[c];
    end
  endtask

  // One clock: push the expectation, let the edge happen, pop and compare, drop one-cycle strobes.
  task automatic cycle();
    exp_t e;
    exp_t x;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    x = sb_q.pop_front();
    chk("sb_clk_out", 32'(clk_out), 32'(x.clk));
    chk("sb_tick", 32'(tick), 32'(x.tck));
    chk("sb_cfg_pending", 32'(cfg_pending), 32'(x.pend));
    chk("sb_cfg_err", 32'(cfg_err), 32'(x.err));
    cfg_wr = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_req = 1'b0;
`endif
  endtask

  task automatic wr(input int ch, input int div);
    cfg_wr  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(div);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    ch_en   = '0;
    cfg_wr  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_req = 1'b0;
`endif
    model_reset();
    #12;
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_pending", 32'(cfg_pending), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);
    reset_n = 1'b1;

    // Default divisor 4 on channel 0: 0,0,1,1 with a tick every 4.
    ch_en = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      cycle();
      hc[i] = clk_out[0];
      ht[i] = tick[0];
    end
    chk("t1_clk_seq", 32'(hc[7:0]), 32'h66);
    chk("t1_tick_seq", 32'(ht[7:0]), 32'h88);

    // Divisor 5 written to channel 1 mid-period, held pending until the wrap.
    ch_en = 5'b00011;
    cycle();
    cycle();
    wr(1, 5);
    chk("t2_pending_set", 32'(cfg_pending[1]), 32'h1);
    cycle();
    chk("t2_pending_clr", 32'(cfg_pending[1]), 32'h0);
    chk("t2_wrap_tick", 32'(tick[1]), 32'h1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      hc[i] = clk_out[1];
    end
    chk("t2_clk_seq", 32'(hc[9:0]), 32'h1CE);

    // Rejected writes: divisor below 2, channel out of range.
    wr(1, 1);
    chk("t3_err_div1", 32'(cfg_err), 32'h1);
    cycle();
    chk("t3_err_clear1", 32'(cfg_err), 32'h0);
    wr(N_CH, 6);
    chk("t3_err_range", 32'(cfg_err), 32'h1);
    cycle();
    chk("t3_err_clear2", 32'(cfg_err), 32'h0);
    chk("t3_no_pending", 32'(cfg_pending), 32'h0);

    // Two writes to channel 2 in one period: only the last one lands.
    ch_en = 5'b00111;
    cycle();
    wr(2, 6);
    wr(2, 8);
    chk("t4_pending", 32'(cfg_pending[2]), 32'h1);
    cycle();
    chk("t4_wrap_tick", 32'(tick[2]), 32'h1);
    chk("t4_pending_clr", 32'(cfg_pending[2]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      hc[i] = clk_out[2];
      ht[i] = tick[2];
    end
    chk("t4_clk_seq", 32'(hc[7:0]), 32'h78);
    chk("t4_tick_seq", 32'(ht[7:0]), 32'h80);

    // Channel 0 disabled for 3 cycles; a write while disabled applies on the next edge.
    ch_en = 5'b00110;
    cycle();
    chk("t5_dis_clk", 32'(clk_out[0]), 32'h0);
    chk("t5_dis_tick", 32'(tick[0]), 32'h0);
    wr(0, 6);
    chk("t5_dis_pending", 32'(cfg_pending[0]), 32'h1);
    cycle();
    chk("t5_dis_applied", 32'(cfg_pending[0]), 32'h0);
    chk("t5_dis_clk2", 32'(clk_out[0]), 32'h0);
    ch_en = 5'b00111;
    for (int i = 0; i < 6; i++) begin
      cycle();
      hc[i] = clk_out[0];
      ht[i] = tick[0];
    end
    chk("t5_clk_seq", 32'(hc[5:0]), 32'h1C);
    chk("t5_tick_seq", 32'(ht[5:0]), 32'h20);

    // Asynchronous reset mid-count with a divisor pending on channel 3.
    wr(3, 9);
    chk("t6_pre_pending", 32'(cfg_pending[3]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_clk", 32'(clk_out), 32'h0);
    chk("t6_async_tick", 32'(tick), 32'h0);
    chk("t6_async_pending", 32'(cfg_pending), 32'h0);
    chk("t6_async_err", 32'(cfg_err), 32'h0);
    model_reset();
    #2;
    reset_n = 1'b1;
    ch_en = 5'b00010;
    for (int i = 0; i < 8; i++) begin
      cycle();
      hc[i] = clk_out[1];
      ht[i] = tick[1];
    end
    chk("t6_default_clk", 32'(hc[7:0]), 32'h66);
    chk("t6_default_tick", 32'(ht[7:0]), 32'h88);

`ifdef CLKDIV_SYNC_EN
    // Staggered starts, then one sync pulse puts channels 0-3 in phase.
    ch_en = 5'b00011;
    cycle();
    ch_en = 5'b00111;
    cycle();
    ch_en = 5'b01111;
    cycle();
    cycle();
    sync_req = 1'b1;
    cycle();
    chk("sync_clk_zero", 32'(clk_out), 32'h0);
    chk("sync_tick_zero", 32'(tick), 32'h0);
    pat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("sync_phase", 32'(clk_out[3:0]), 32'({4{pat[i]}}));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
